// File: rtl/dac_playback_buffer.sv
// Waveform playback buffer: a single-clock waveform RAM streamed out as an AXI4-Stream master,
// played once or looped, with an optional sysref-aligned start.
module dac_playback_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  aclk,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_BITS-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_BITS-1:0]  len_i,
    input  logic                  loop_i,
    input  logic                  sync_mode_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  sync_i,
    output logic [DATA_WIDTH-1:0] dac_tdata,
    output logic                  dac_tvalid,
    input  logic                  dac_tready,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           pass_count_o
);

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, ARM, PRIME, PLAY} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t state, state_next;

    logic [ADDR_BITS-1:0]  len_q;
    logic                  loop_q;
    logic                  stop_q;
    logic                  fetch_en;
    logic [ADDR_BITS-1:0]  addr_q;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    logic [DATA_WIDTH-1:0] data_p1, data_p2;
    logic                  last_p1, last_p2;
    logic                  vld_p1, vld_p2;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            count;

    logic                  pop, last_hs, end_pass, flush;
    logic                  issue, issue_last, credit;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic [2:0]            occ;

    assign dac_tvalid = (count != 3'd0);
    assign dac_tdata  = dac_tvalid ? fifo_data[rd_ptr] : '0;
    assign busy_o     = (state != IDLE);

    assign pop      = dac_tvalid && dac_tready;
    assign last_hs  = pop && fifo_last[rd_ptr];
    assign end_pass = (state == PLAY) && last_hs && (!loop_q || stop_q || stop_i);
    assign flush    = end_pass || ((state == ARM) && stop_i);

    // Reads are only issued when the beat is guaranteed a FIFO slot once it
    // leaves the two-stage read pipeline, so a stall never drops a beat.
    assign occ        = 3'(vld_p1) + 3'(vld_p2) + count;
    assign credit     = (occ - 3'(pop)) < 3'(FIFO_DEPTH);
    assign rd_addr    = (state == PRIME) ? '0 : addr_q;
    assign issue_last = (rd_addr == len_q);
    assign issue      = (state == PRIME) || ((state == PLAY) && fetch_en && credit);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = sync_mode_i ? ARM : PRIME;
            ARM: begin
                if (stop_i)      state_next = IDLE;
                else if (sync_i) state_next = PRIME;
            end
            PRIME:   state_next = PLAY;
            PLAY:    if (end_pass) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            state        <= IDLE;
            len_q        <= '0;
            loop_q       <= 1'b0;
            stop_q       <= 1'b0;
            done_o       <= 1'b0;
            pass_count_o <= '0;
            fetch_en     <= 1'b0;
            addr_q       <= '0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            state  <= state_next;
            done_o <= end_pass;

            if (state == IDLE && start_i) begin
                len_q        <= len_i;
                loop_q       <= loop_i;
                stop_q       <= 1'b0;
                pass_count_o <= '0;
            end else begin
                if (state == PLAY && stop_i) stop_q <= 1'b1;
                if (last_hs) pass_count_o <= sat_inc16(pass_count_o);
            end

            if (flush) begin
                fetch_en <= 1'b0;
                vld_p1   <= 1'b0;
                vld_p2   <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                vld_p1 <= issue;
                vld_p2 <= vld_p1;
                if (vld_p2) wr_ptr <= wr_ptr + 2'd1;
                if (pop)    rd_ptr <= rd_ptr + 2'd1;
                count <= count + 3'(vld_p2) - 3'(pop);
                if (issue) begin
                    addr_q   <= issue_last ? '0 : rd_addr + 1'b1;
                    fetch_en <= !(issue_last && !loop_q);
                end
            end
        end
    end

    // Read pipeline: RAM output register (p1), prefetch register (p2), then FIFO.
    always_ff @(posedge aclk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (issue) begin
            data_p1 <= mem[rd_addr];
            last_p1 <= issue_last;
        end
        data_p2 <= data_p1;
        last_p2 <= last_p1;
        if (vld_p2) begin
            fifo_data[wr_ptr] <= data_p2;
            fifo_last[wr_ptr] <= last_p2;
        end
    end

endmodule

// File: tb/tb_dac_playback_buffer.sv
// Scoreboard bench for dac_playback_buffer: stimulus queues expected beats, a negedge monitor
// pops and compares on every stream handshake.
module tb_dac_playback_buffer;

    localparam int DW = 128;
    localparam int AB = 10;

    logic          aclk = 1'b0;
    logic          reset_i, wr_en_i, loop_i, sync_mode_i, start_i, stop_i, sync_i;
    logic [AB-1:0] wr_addr_i, len_i;
    logic [DW-1:0] wr_data_i, dac_tdata;
    logic          dac_tvalid, dac_tready, busy_o, done_o;
    logic [15:0]   pass_count_o;

    always #5 aclk = ~aclk;

    dac_playback_buffer #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .aclk(aclk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .len_i(len_i), .loop_i(loop_i), .sync_mode_i(sync_mode_i),
        .start_i(start_i), .stop_i(stop_i), .sync_i(sync_i), .dac_tdata(dac_tdata),
        .dac_tvalid(dac_tvalid), .dac_tready(dac_tready), .busy_o(busy_o),
        .done_o(done_o), .pass_count_o(pass_count_o)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [16];
    int hs_total = 0, done_cnt = 0, done_edge = 0, rise_edge = 0, vld_cycles = 0;
    logic prev_vld = 1'b0, stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    function automatic logic [DW-1:0] pat(input logic [15:0] v);
        return {8{v}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (dac_tvalid && !prev_vld) rise_edge = cyc;
        if (dac_tvalid) vld_cycles++;
        if (!dac_tvalid) check("tdata_zero_when_invalid", dac_tdata, '0);
        if (stall_prev) begin
            check("stall_hold_valid", {127'd0, dac_tvalid}, 1);
            check("stall_hold_data", dac_tdata, prev_data);
        end
        if (dac_tvalid && dac_tready) begin
            hs_total++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h required=none", dac_tdata);
            end else begin
                check("beat", dac_tdata, exp_q.pop_front());
            end
        end
        if (done_o) begin
            done_cnt++;
            done_edge = cyc;
        end
        stall_prev = dac_tvalid && !dac_tready && !reset_i;
        prev_vld   = dac_tvalid;
        prev_data  = dac_tdata;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en_i = 1'b1; wr_addr_i = AB'(a); wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
        if (a < 16) model[a] = d;
    endtask

    task automatic start(input int len, input logic lp, input logic sm, output int edge_n);
        len_i = AB'(len); loop_i = lp; sync_mode_i = sm; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        edge_n = cyc;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int maxc, input logic rnd);
        int n = 0;
        while (done_cnt == d0 && n < maxc) begin
            if (rnd) dac_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        dac_tready = 1'b1;
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", maxc);
        end
    endtask

    task automatic wait_pass(input int p, input int maxc);
        int n = 0;
        while (int'(pass_count_o) < p && n < maxc) begin
            tick();
            n++;
        end
        check("pass_wait", pass_count_o, p);
    endtask

    task automatic push_pass(input int len);
        for (int k = 0; k <= len; k++) exp_q.push_back(model[k]);
    endtask

    int n_edge, s_edge, d0, v0, base;

    initial begin
        reset_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; len_i = '0;
        loop_i = 1'b0; sync_mode_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; sync_i = 1'b0;
        dac_tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", {127'd0, dac_tvalid}, 0);
        check("rst_busy", {127'd0, busy_o}, 0);
        check("rst_done", {127'd0, done_o}, 0);
        check("rst_pass", pass_count_o, 0);
        reset_i = 1'b0;
        tick();

        // Single pass, len=15, tready high
        for (int k = 0; k < 16; k++) wr(k, pat(16'(k)));
        push_pass(15);
        d0 = done_cnt;
        start(15, 1'b0, 1'b0, n_edge);
        wait_done(d0, 60, 1'b0);
        repeat (2) tick();
        check("t1_first_valid_latency", rise_edge - n_edge, 3);
        check("t1_done_edge", done_edge - n_edge, 19);
        check("t1_pass_count", pass_count_o, 1);
        check("t1_busy_after", {127'd0, busy_o}, 0);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_done_once", done_cnt - d0, 1);

        // Loop with stop in pass 3
        for (int p = 0; p < 3; p++) push_pass(15);
        d0 = done_cnt;
        start(15, 1'b1, 1'b0, n_edge);
        wait_pass(2, 100);
        repeat (5) tick();
        pulse_stop();
        wait_done(d0, 100, 1'b0);
        repeat (2) tick();
        check("t2_pass_count", pass_count_o, 3);
        check("t2_gapless_span", done_edge - rise_edge, 48);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_done_once", done_cnt - d0, 1);

        // Random backpressure, len=7
        push_pass(7);
        d0 = done_cnt;
        start(7, 1'b0, 1'b0, n_edge);
        wait_done(d0, 300, 1'b1);
        repeat (2) tick();
        check("t3_pass_count", pass_count_o, 1);
        check("t3_queue_empty", exp_q.size(), 0);
        check("t3_done_once", done_cnt - d0, 1);

        // Sync mode: coincident sync ignored, second sync starts playback
        push_pass(3);
        d0 = done_cnt;
        v0 = vld_cycles;
        len_i = AB'(3); loop_i = 1'b0; sync_mode_i = 1'b1; start_i = 1'b1; sync_i = 1'b1;
        tick();
        start_i = 1'b0; sync_i = 1'b0;
        s_edge = cyc;
        repeat (9) tick();
        check("t4_busy_armed", {127'd0, busy_o}, 1);
        check("t4_no_valid_armed", vld_cycles - v0, 0);
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        wait_done(d0, 50, 1'b0);
        repeat (2) tick();
        check("t4_sync_latency", rise_edge - s_edge, 13);
        check("t4_queue_empty", exp_q.size(), 0);

        // Stop while armed
        d0 = done_cnt;
        v0 = vld_cycles;
        start(7, 1'b0, 1'b1, n_edge);
        repeat (3) tick();
        pulse_stop();
        check("t4_arm_stop_busy", {127'd0, busy_o}, 0);
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        repeat (5) tick();
        check("t4_arm_stop_no_valid", vld_cycles - v0, 0);
        check("t4_arm_stop_no_done", done_cnt - d0, 0);
        check("t4_arm_stop_idle", {127'd0, busy_o}, 0);

        // Overwrite beat 3 while looping; start during PLAY ignored
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++)
                exp_q.push_back((p >= 2 && k == 3) ? pat(16'hDEAD) : model[k]);
        d0 = done_cnt;
        start(7, 1'b1, 1'b0, n_edge);
        wait_pass(1, 50);
        repeat (5) tick();
        wr(3, pat(16'hDEAD));
        start_i = 1'b1; len_i = AB'(2); loop_i = 1'b0;
        tick();
        start_i = 1'b0;
        check("t5_start_ignored_pass", pass_count_o, 1);
        check("t5_start_ignored_busy", {127'd0, busy_o}, 1);
        wait_pass(3, 100);
        repeat (2) tick();
        pulse_stop();
        wait_done(d0, 100, 1'b0);
        repeat (2) tick();
        check("t5_pass_count", pass_count_o, 4);
        check("t5_queue_empty", exp_q.size(), 0);

        // Reset while beat 5 is stalled, then replay
        push_pass(7);
        d0 = done_cnt;
        base = hs_total;
        start(7, 1'b0, 1'b0, n_edge);
        for (int n = 0; n < 50 && hs_total < base + 5; n++) tick();
        dac_tready = 1'b0;
        repeat (3) tick();
        check("t6_stalled_valid", {127'd0, dac_tvalid}, 1);
        check("t6_stalled_beat5", dac_tdata, model[5]);
        reset_i = 1'b1;
        tick();
        check("t6_rst_tvalid", {127'd0, dac_tvalid}, 0);
        check("t6_rst_busy", {127'd0, busy_o}, 0);
        check("t6_rst_pass", pass_count_o, 0);
        check("t6_rst_done", {127'd0, done_o}, 0);
        reset_i = 1'b0;
        exp_q.delete();
        dac_tready = 1'b1;
        tick();
        check("t6_no_done_on_reset", done_cnt - d0, 0);
        push_pass(7);
        start(7, 1'b0, 1'b0, n_edge);
        wait_done(d0, 60, 1'b0);
        repeat (2) tick();
        check("t6_replay_pass", pass_count_o, 1);
        check("t6_replay_first_latency", rise_edge - n_edge, 3);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
